// File: rtl/counter_pkg.sv
// Shared types and constants for the time-shared counter scheduler.
package counter_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_RESET = 8'd120;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Turns a requester index into its one-hot grant/done position.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // Single requests win outright; on a tie the pointer hands the turn over.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_sched.sv
// One 8-bit up-counter time-shared between two requesters. A winner gets a
// run of len counts starting at its base value; the run ends with a one-cycle
// DONE pulse, or silently if the owner drops its request early.
module counter_sched
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] base0,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] base1,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic [1:0]       done
);

  localparam logic [CNT_W-1:0] ONE  = 1;
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;

  logic [1:0]       win;
  logic             winIdx;
  logic [CNT_W-1:0] winBase;
  logic [CNT_W-1:0] winLen;

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  assign winIdx  = win[1];
  assign winBase = winIdx ? base1 : base0;
  assign winLen  = winIdx ? len1 : len0;

  // Next-state logic: arbitrate in IDLE, count down the run, pulse on completion.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (req != 2'b00) begin
          owner_d = winIdx;
          count_d = winBase;
          rem_d   = winLen;
          if (winLen == ZERO) begin
            state_d = DONE;
            done_d  = onehot2(winIdx);
          end else begin
            state_d = RUN;
            gnt_d   = onehot2(winIdx);
          end
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          rem_d   = ZERO;
          last_d  = owner_q;
        end else if (rem_q == ONE) begin
          state_d = DONE;
          gnt_d   = 2'b00;
          rem_d   = ZERO;
          done_d  = onehot2(owner_q);
        end else begin
          count_d = count_q + ONE;
          rem_d   = rem_q - ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = owner_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // All scheduler state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= CNT_RESET;
      rem_q   <= ZERO;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt   = gnt_q;
  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed vector table, hand-written
// corner sequences and randomized traffic against a run-queue reference model.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] base0, len0, base1, len1;
  logic [1:0] gnt, done;
  logic [7:0] count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  counter_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .base0 (base0),
    .len0  (len0),
    .base1 (base1),
    .len1  (len1),
    .gnt   (gnt),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model: a granted run is the list of values the owner should see.
  int         mPhase;
  int         mOwner;
  int         mLast;
  logic [7:0] mSeq[$];
  logic [7:0] mCount;
  logic [1:0] mDone;

  function automatic void modelReset();
    mPhase = 0;
    mOwner = 0;
    mLast  = 1;
    mSeq.delete();
    mCount = 8'd120;
    mDone  = 2'b00;
  endfunction

  function automatic void modelStep();
    int w;
    logic [7:0] b, l;
    mDone = 2'b00;
    if (mPhase == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = (mLast == 1) ? 0 : 1;
        else              w = req[0] ? 0 : 1;
        b = (w == 1) ? base1 : base0;
        l = (w == 1) ? len1 : len0;
        mOwner = w;
        mSeq.delete();
        for (int k = 0; k < int'(l); k++) mSeq.push_back(8'(int'(b) + k));
        mCount = b;
        if (l == 8'd0) begin
          mPhase = 2;
          mDone  = (w == 1) ? 2'b10 : 2'b01;
        end else begin
          mPhase = 1;
        end
      end
    end else if (mPhase == 1) begin
      if (!req[mOwner]) begin
        mPhase = 0;
        mLast  = mOwner;
      end else begin
        void'(mSeq.pop_front());
        if (mSeq.size() == 0) begin
          mPhase = 2;
          mDone  = (mOwner == 1) ? 2'b10 : 2'b01;
        end else begin
          mCount = mSeq[0];
        end
      end
    end else begin
      mPhase = 0;
      mLast  = mOwner;
    end
  endfunction

  function automatic logic [1:0] modelGnt();
    if (mPhase == 1) return (mOwner == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Drive one cycle of inputs on the falling edge, then advance the model.
  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] b0,
                               input logic [7:0] l0, input logic [7:0] b1,
                               input logic [7:0] l1);
    @(negedge clk);
    req   = r;
    base0 = b0;
    len0  = l0;
    base1 = b1;
    len1  = l1;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eGnt,
                             input logic [7:0] eCount, input logic eBusy,
                             input logic [1:0] eDone);
    checks++;
    if (gnt !== eGnt || count !== eCount || busy !== eBusy || done !== eDone) begin
      failures++;
      $display("[TB] FAIL %s: got gnt=%b count=%0d busy=%b done=%b, expected gnt=%b count=%0d busy=%b done=%b",
               name, gnt, count, busy, done, eGnt, eCount, eBusy, eDone);
    end
  endtask

  typedef struct {
    logic [1:0] r;
    logic [7:0] b0, l0, b1, l1;
    logic [1:0] eGnt;
    logic [7:0] eCount;
    logic       eBusy;
    logic [1:0] eDone;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [1:0] r, input logic [7:0] b0, input logic [7:0] l0,
                        input logic [7:0] b1, input logic [7:0] l1, input logic [1:0] eGnt,
                        input logic [7:0] eCount, input logic eBusy, input logic [1:0] eDone);
    vec_t v;
    v.r = r; v.b0 = b0; v.l0 = l0; v.b1 = b1; v.l1 = l1;
    v.eGnt = eGnt; v.eCount = eCount; v.eBusy = eBusy; v.eDone = eDone;
    vecs.push_back(v);
  endtask

  initial begin
    req = 2'b00; base0 = 8'd0; len0 = 8'd0; base1 = 8'd0; len1 = 8'd0;
    rst_n = 1'b0;
    modelReset();

    // Single run on requester 0; base/len wiggle mid-run must not matter.
    addVec(2'b01, 8'd5, 8'd3, 8'd0, 8'd0, 2'b01, 8'd5, 1'b1, 2'b00);
    addVec(2'b01, 8'd99, 8'd1, 8'd0, 8'd0, 2'b01, 8'd6, 1'b1, 2'b00);
    addVec(2'b01, 8'd99, 8'd1, 8'd0, 8'd0, 2'b01, 8'd7, 1'b1, 2'b00);
    addVec(2'b01, 8'd99, 8'd1, 8'd0, 8'd0, 2'b00, 8'd7, 1'b1, 2'b01);
    addVec(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 8'd7, 1'b0, 2'b00);
    // Requester 1 run wrapping through 255 -> 0.
    addVec(2'b10, 8'd0, 8'd0, 8'd254, 8'd4, 2'b10, 8'd254, 1'b1, 2'b00);
    addVec(2'b10, 8'd0, 8'd0, 8'd254, 8'd4, 2'b10, 8'd255, 1'b1, 2'b00);
    addVec(2'b10, 8'd0, 8'd0, 8'd254, 8'd4, 2'b10, 8'd0, 1'b1, 2'b00);
    addVec(2'b10, 8'd0, 8'd0, 8'd254, 8'd4, 2'b10, 8'd1, 1'b1, 2'b00);
    addVec(2'b10, 8'd0, 8'd0, 8'd254, 8'd4, 2'b00, 8'd1, 1'b1, 2'b10);
    addVec(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 8'd1, 1'b0, 2'b00);
    // Both requesting: grants alternate 01, 10, 01 with an IDLE gap each time.
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b01, 8'd10, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b01, 8'd11, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd11, 1'b1, 2'b01);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd11, 1'b0, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b10, 8'd50, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b10, 8'd51, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd51, 1'b1, 2'b10);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd51, 1'b0, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b01, 8'd10, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b01, 8'd11, 1'b1, 2'b00);
    addVec(2'b11, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd11, 1'b1, 2'b01);
    addVec(2'b00, 8'd10, 8'd2, 8'd50, 8'd2, 2'b00, 8'd11, 1'b0, 2'b00);
    // Zero-length run goes straight to DONE.
    addVec(2'b01, 8'd9, 8'd0, 8'd0, 8'd0, 2'b00, 8'd9, 1'b1, 2'b01);
    addVec(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 8'd9, 1'b0, 2'b00);

    #12;
    checkOutput("reset_async", 2'b00, 8'd120, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
      checkOutput("idle_after_reset", 2'b00, 8'd120, 1'b0, 2'b00);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].b0, vecs[i].l0, vecs[i].b1, vecs[i].l1);
      checkOutput($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eCount,
                  vecs[i].eBusy, vecs[i].eDone);
    end

    // Owner drops its request on the third RUN cycle: silent abort.
    applyStimulus(2'b01, 8'd30, 8'd10, 8'd0, 8'd0);
    checkOutput("abort_run1", 2'b01, 8'd30, 1'b1, 2'b00);
    applyStimulus(2'b01, 8'd30, 8'd10, 8'd0, 8'd0);
    checkOutput("abort_run2", 2'b01, 8'd31, 1'b1, 2'b00);
    applyStimulus(2'b01, 8'd30, 8'd10, 8'd0, 8'd0);
    checkOutput("abort_run3", 2'b01, 8'd32, 1'b1, 2'b00);
    applyStimulus(2'b00, 8'd30, 8'd10, 8'd0, 8'd0);
    checkOutput("abort_idle", 2'b00, 8'd32, 1'b0, 2'b00);
    applyStimulus(2'b00, 8'd30, 8'd10, 8'd0, 8'd0);
    checkOutput("abort_nodone", 2'b00, 8'd32, 1'b0, 2'b00);

    // Reset in the middle of a run clears everything immediately.
    applyStimulus(2'b10, 8'd0, 8'd0, 8'd77, 8'd20);
    checkOutput("rst_run1", 2'b10, 8'd77, 1'b1, 2'b00);
    applyStimulus(2'b10, 8'd0, 8'd0, 8'd77, 8'd20);
    checkOutput("rst_run2", 2'b10, 8'd78, 1'b1, 2'b00);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    checkOutput("reset_midrun", 2'b00, 8'd120, 1'b0, 2'b00);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("post_reset_idle", 2'b00, 8'd120, 1'b0, 2'b00);
    applyStimulus(2'b11, 8'd40, 8'd1, 8'd60, 8'd1);
    checkOutput("rr_favours_0", 2'b01, 8'd40, 1'b1, 2'b00);
    applyStimulus(2'b11, 8'd40, 8'd1, 8'd60, 8'd1);
    checkOutput("len1_done", 2'b00, 8'd40, 1'b1, 2'b01);
    applyStimulus(2'b00, 8'd40, 8'd1, 8'd60, 8'd1);
    checkOutput("len1_idle", 2'b00, 8'd40, 1'b0, 2'b00);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
      applyStimulus(r, 8'($urandom), 8'($urandom_range(0, 6)),
                    8'($urandom), 8'($urandom_range(0, 6)));
      checkOutput("random", modelGnt(), mCount, (mPhase != 0), mDone);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
